// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit period.
// Used by both the receive and transmit paths.
package uart_pkg;

    // 12 MHz clock / 115200 baud, rounded to the nearest whole cycle
    localparam int unsigned UART_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Every stage resets to 1, the idle level of a UART line.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 1) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 1");
    end

    logic [STAGES-1:0] sync_q;

    // shift chain, oldest sample in the MSB
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with valid/ready output handshake, frame-error and
// overrun pulses. Bits are sampled mid-period on the synchronized line.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk_12p0,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxs_s;
    logic             rxs_prev_q;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             stop_ok_s;
    logic             stop_bad_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_12p0),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rxs_s)
    );

    // previous synchronized sample for start-edge detection
    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            rxs_prev_q <= 1'b1;
        end else begin
            rxs_prev_q <= rxs_s;
        end
    end

    // frame sequencing: start qualification, data shifting, stop sampling
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        stop_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!rxs_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rxs_s) begin
                        stop_ok_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // output holding register: a delivery only wins if the slot is free or being drained
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q && !ready_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        if (stop_ok_s) begin
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else begin
            ferr_d = stop_bad_s;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // registered outputs
    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: directed scenarios plus a randomized
// frame stream compared against a frame-level reference model.
module tb_uart_rx_8n1;

    localparam int CPB = 104;

    logic       clk_12p0 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_i     = 1'b1;
    logic       ready_i  = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #5 clk_12p0 = ~clk_12p0;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_12p0    (clk_12p0),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // observation counters, sampled on the falling edge
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    int         rise_cnt = 0;
    int         valid_cyc = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         both_cnt = 0;
    int         busy_rise_cnt = 0;
    int         busy_cyc = 0;
    int         acc_n = 0;
    logic [7:0] acc_mem [0:255];
    logic       valid_prev = 1'b0;
    logic       busy_prev = 1'b0;

    always @(negedge clk_12p0) begin
        cyc        <= cyc + 1;
        valid_prev <= valid_o;
        busy_prev  <= busy_o;
        if (valid_o && !valid_prev) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc + 1;
        end
        if (valid_o) valid_cyc <= valid_cyc + 1;
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o) ovr_cnt <= ovr_cnt + 1;
        if (frame_err_o && overrun_o) both_cnt <= both_cnt + 1;
        if (busy_o && !busy_prev) busy_rise_cnt <= busy_rise_cnt + 1;
        if (busy_o) busy_cyc <= busy_cyc + 1;
        if (valid_o && ready_i) begin
            acc_mem[acc_n] <= data_o;
            acc_n          <= acc_n + 1;
        end
    end

    task automatic idle(input int n);
        #1 rx_i = 1'b1;
        repeat (n) @(posedge clk_12p0);
    endtask

    // start bit, 8 data bits LSB first, then the given stop level
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        #1;
        start_cyc = cyc;
        rx_i = 1'b0;
        repeat (CPB) @(posedge clk_12p0);
        for (int i = 0; i < 8; i++) begin
            #1 rx_i = b[i];
            repeat (CPB) @(posedge clk_12p0);
        end
        #1 rx_i = stop_bit;
        repeat (CPB) @(posedge clk_12p0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
        repeat (3) @(posedge clk_12p0);
        #1;
        n_cmp++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(posedge clk_12p0);
        #1 rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single();
        int r0, a0, f0, o0, v0, lat;
        ready_i = 1'b1;
        @(posedge clk_12p0);
        r0 = rise_cnt; a0 = acc_n; f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
        send_byte(8'h55, 1'b1);
        idle(4);
        #1;
        lat = rise_cyc - start_cyc;
        n_cmp++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_rises: got %0d want 1", rise_cnt - r0); end
        n_cmp++; if (valid_cyc - v0 !== 1) begin n_fail++; $display("FAIL single_valid_len: got %0d want 1", valid_cyc - v0); end
        n_cmp++; if (acc_n - a0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", acc_n - a0); end
        n_cmp++; if (acc_mem[a0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", acc_mem[a0]); end
        n_cmp++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_fail++; $display("FAIL single_err: got %0d pulses want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
        n_cmp++; if (lat < (CPB * 19) / 2 || lat > CPB * 10) begin n_fail++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, (CPB * 19) / 2, CPB * 10); end
    endtask

    task automatic test_back_to_back();
        int a0, r0;
        ready_i = 1'b1;
        @(posedge clk_12p0);
        a0 = acc_n; r0 = rise_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        #1;
        n_cmp++; if (rise_cnt - r0 !== 2) begin n_fail++; $display("FAIL b2b_rises: got %0d want 2", rise_cnt - r0); end
        n_cmp++; if (acc_mem[a0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h want 00", acc_mem[a0]); end
        n_cmp++; if (acc_mem[a0 + 1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", acc_mem[a0 + 1]); end
    endtask

    task automatic test_overrun();
        int a0, o0, f0;
        ready_i = 1'b0;
        @(posedge clk_12p0);
        a0 = acc_n; o0 = ovr_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(4);
        #1;
        n_cmp++; if (data_o !== 8'hA5) begin n_fail++; $display("FAIL ovr_data: got %h want a5", data_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", valid_o); end
        n_cmp++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - o0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL ovr_ferr: got %0d want 0", ferr_cnt - f0); end
        ready_i = 1'b1;
        repeat (2) @(posedge clk_12p0);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", valid_o); end
        n_cmp++; if (acc_n - a0 !== 1 || acc_mem[a0] !== 8'hA5) begin n_fail++; $display("FAIL ovr_accept: got %0d/%h want 1/a5", acc_n - a0, acc_mem[a0]); end
    endtask

    task automatic test_frame_err();
        int a0, f0, r0;
        ready_i = 1'b1;
        @(posedge clk_12p0);
        a0 = acc_n; f0 = ferr_cnt; r0 = rise_cnt;
        send_byte(8'h81, 1'b0);
        idle(CPB);
        #1;
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d rises want 0", rise_cnt - r0); end
        send_byte(8'h42, 1'b1);
        idle(4);
        #1;
        n_cmp++; if (acc_n - a0 !== 1 || acc_mem[a0] !== 8'h42) begin n_fail++; $display("FAIL ferr_next: got %0d/%h want 1/42", acc_n - a0, acc_mem[a0]); end
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_after: got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_glitch();
        int b0, bc0, r0, f0;
        ready_i = 1'b1;
        @(posedge clk_12p0);
        b0 = busy_rise_cnt; bc0 = busy_cyc; r0 = rise_cnt; f0 = ferr_cnt;
        #1 rx_i = 1'b0;
        repeat (20) @(posedge clk_12p0);
        idle(2 * CPB);
        #1;
        n_cmp++; if (busy_rise_cnt - b0 !== 1) begin n_fail++; $display("FAIL glitch_busy_rise: got %0d want 1", busy_rise_cnt - b0); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy_o); end
        n_cmp++; if (busy_cyc - bc0 < CPB / 2 - 1 || busy_cyc - bc0 > CPB / 2 + 1) begin n_fail++; $display("FAIL glitch_busy_len: got %0d want about %0d", busy_cyc - bc0, CPB / 2); end
        n_cmp++; if ((rise_cnt - r0) + (ferr_cnt - f0) !== 0) begin n_fail++; $display("FAIL glitch_output: got %0d events want 0", (rise_cnt - r0) + (ferr_cnt - f0)); end
    endtask

    task automatic test_reset_mid_frame();
        int a0, f0;
        logic [7:0] junk;
        ready_i = 1'b0;
        @(posedge clk_12p0);
        send_byte(8'h5A, 1'b1);
        idle(4);
        #1;
        n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_preload: got %b want 1", valid_o); end
        junk = 8'($urandom_range(0, 255));
        #1 rx_i = 1'b0;
        repeat (CPB) @(posedge clk_12p0);
        for (int i = 0; i < 4; i++) begin
            #1 rx_i = junk[i];
            repeat (CPB) @(posedge clk_12p0);
        end
        #1 rx_i = junk[4];
        repeat (CPB / 2) @(posedge clk_12p0);
        #3;
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy_o); end
        rst_n = 1'b0;
        rx_i  = 1'b1;
        #1;
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_out: got %b/%h want 0/00", valid_o, data_o); end
        n_cmp++; if ({busy_o, frame_err_o, overrun_o} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {busy_o, frame_err_o, overrun_o}); end
        repeat (3) @(posedge clk_12p0);
        #1 rst_n = 1'b1;
        ready_i = 1'b1;
        idle(8);
        a0 = acc_n; f0 = ferr_cnt;
        send_byte(8'hC3, 1'b1);
        idle(4);
        #1;
        n_cmp++; if (acc_n - a0 !== 1 || acc_mem[a0] !== 8'hC3) begin n_fail++; $display("FAIL rstmid_next: got %0d/%h want 1/c3", acc_n - a0, acc_mem[a0]); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    // random bytes and stop levels; model: good stops deliver in order, bad stops pulse once
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       stop_bit;
        int         a0, f0, o0, bad, gap;
        ready_i = 1'b1;
        @(posedge clk_12p0);
        a0 = acc_n; f0 = ferr_cnt; o0 = ovr_cnt; bad = 0;
        for (int k = 0; k < 16; k++) begin
            b        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            send_byte(b, stop_bit);
            if (stop_bit) begin
                exp_q.push_back(b);
                gap = $urandom_range(0, 3);
            end else begin
                bad++;
                gap = $urandom_range(4, 12);
            end
            idle(gap);
        end
        idle(CPB);
        #1;
        n_cmp++; if (acc_n - a0 !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", acc_n - a0, exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (acc_mem[a0 + k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", k, acc_mem[a0 + k], exp_q[k]); end
        end
        n_cmp++; if (ferr_cnt - f0 !== bad) begin n_fail++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, bad); end
        n_cmp++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL rand_ovr: got %0d want 0", ovr_cnt - o0); end
        n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL err_exclusive: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk_12p0 cycles per bit (12 MHz / 115200 baud, rounded).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the rx_i synchronizer.
REQ-003 SHALL have port clk_12p0  input  1  sole clock, 12 MHz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line from the board pin (ICE_9), idle high.
REQ-006 SHALL have port data_o  output  8  received byte, valid while valid_o=1.
REQ-007 SHALL have port valid_o  output  1  byte available; held until accepted.
REQ-008 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o&&ready_i.
REQ-009 SHALL have port frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx_i through SYNC_STAGES flops, reset to 1; all logic uses only the synchronized value rxs.
REQ-013 SHALL implement an FSM with states IDLE, START, DATA and STOP, and a bit counter of width $clog2(CLKS_PER_BIT).
REQ-014 SHALL, in IDLE, enter START and clear the counter on a falling edge of rxs (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-015 SHALL, in START, sample rxs at counter==CLKS_PER_BIT/2-1: if 0, enter DATA and clear the counter; if 1, treat it as a glitch and return to IDLE with no output.
REQ-016 SHALL, in DATA, sample rxs each time counter==CLKS_PER_BIT-1, shift it LSB-first into the shift register, and clear the counter; after the 8th bit it enters STOP.
REQ-017 SHALL, in STOP, sample rxs at counter==CLKS_PER_BIT-1 and return to IDLE in that same cycle (mid-stop-bit), so back-to-back frames are received.
REQ-018 SHALL, when the stop sample is 1, deliver the byte: data_o and valid_o update on the next edge (1-cycle latency after the stop sample).
REQ-019 SHALL, when the stop sample is 0, pulse frame_err_o for one cycle, discard the byte, and leave valid_o/data_o unchanged.
REQ-020 SHALL hold data_o stable while valid_o=1 and clear valid_o the cycle after valid_o&&ready_i, unless a new byte is delivered in that same cycle.
REQ-021 SHALL, when delivery coincides with valid_o&&ready_i, load the new byte, keep valid_o=1, and not pulse overrun_o.
REQ-022 SHALL, when delivery occurs while valid_o=1 and ready_i=0, keep the old byte, drop the new one, and pulse overrun_o for one cycle.
REQ-023 SHALL ensure frame_err_o and overrun_o are never asserted in the same cycle, since each requires a different stop-bit value.
REQ-024 SHALL reject CLKS_PER_BIT<4 at elaboration.

Reset
REQ-025 SHALL, on rst_n=0 and regardless of clock, set the FSM to IDLE, counters and shift register to 0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, and synchronizer flops to 1.
REQ-026 SHALL abandon a frame interrupted by reset with no output, and SHALL receive the next full frame after release normally.

Structure
REQ-027 SHALL take the FSM state enum and the default CLKS_PER_BIT constant from shared package uart_pkg, which is also used by the transmit side.
REQ-028 SHALL implement the input synchronizer as sub-module sync_ff (parameter STAGES, reset value 1); all other logic is inline.

Verification
REQ-029 SHALL verify: frame 0x55 at 104 clk/bit with ready_i=1 -> valid_o one cycle, data_o=0x55, no error pulses.
REQ-030 SHALL verify: bytes 0x00 then 0xFF back-to-back with ready_i=1 -> two valid_o pulses, data 0x00 then 0xFF.
REQ-031 SHALL verify: 0xA5 received with ready_i=0, then 0x3C -> data_o stays 0xA5, overrun_o pulses once, and ready_i=1 then clears valid_o.
REQ-032 SHALL verify: 0x81 with the stop bit driven 0 -> frame_err_o pulses once, valid_o stays 0, and the following normal 0x42 is received.
REQ-033 SHALL verify: a 20-cycle low glitch on rx_i -> busy_o rises then falls at the half-bit check, with no valid_o and no frame_err_o.
REQ-034 SHALL verify: rst_n asserted during bit 4 of a frame -> all outputs 0 immediately; after release, frame 0xC3 yields data_o=0xC3.
